puzzle_move_ctrl: RTL
=====================

Name: puzzle_move_ctrl

Overview:
- Game controller for the 8-puzzle board datapath.
- Turns debounced button levels into tile moves on a 3x3 board register, with blank-tile tracking.
- Runs an LFSR-driven shuffle on the center button, keeps a BCD move counter for the four 7-segment digits, and flags the solved state.
- Sits between the button debouncers and the board renderer / seg0..seg3 decoders inside top.

Parameters:
- SHUFFLE_MOVES, 64, number of legal random moves applied per shuffle (1..255).
- LFSR_SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- btn  in  5  debounced button levels: [0] up, [1] down, [2] left, [3] right, [4] center (shuffle/start).
- board  out  36  tile at position i in board[4i+3:4i]; positions 0..8 row-major; 0 = blank, 1..8 = tiles.
- blank_pos  out  4  current position of the blank, 0..8.
- move_cnt  out  16  four BCD digits: [15:12] thousands … [3:0] units.
- solved  out  1  high while state is SOLVED.
- busy  out  1  high while state is SHUF.

Behaviour:
- Clocking and reset:
  - Single clock; rst_n asynchronous active-low.
  - All state is registered.
- Reset values:
  - board = 36'h0_8765_4321 (goal); blank_pos = 8; move_cnt = 16'h0000.
  - state = SOLVED, so solved = 1 and busy = 0.
  - btn_q = 5'b0; lfsr = LFSR_SEED; shuffle counter = 0.
- Edge detection:
  - btn_q <= btn every cycle in every state.
  - rise = btn & ~btn_q. Only rises are acted on; held buttons do nothing further.
- Move semantics: direction d moves the blank; the neighbour tile swaps into the old blank position.
  - up: legal if blank_pos >= 3; new position = blank_pos - 3.
  - down: legal if blank_pos <= 5; new position = blank_pos + 3.
  - left: legal if blank_pos % 3 != 0; new position = blank_pos - 1.
  - right: legal if blank_pos % 3 != 2; new position = blank_pos + 1.
  - Each move is single-cycle: board and blank_pos update on the same edge that sees the rise.
- Priority when several rises land in the same cycle: center > up > down > left > right. Lower-priority rises are dropped.
- LFSR:
  - 16-bit Fibonacci LFSR, shifts left every cycle in every state.
  - Feedback bit = l[15]^l[13]^l[12]^l[10].
  - The shuffle direction code is lfsr[1:0]: 0 up, 1 down, 2 left, 3 right.
- FSM states:
  - SOLVED:
    - Direction rises are ignored.
    - Center rise -> SHUF; load shuffle counter with SHUFFLE_MOVES.
  - SHUF:
    - busy = 1; all button rises are ignored.
    - Each cycle, decode lfsr[1:0]. If the move is legal, apply it and decrement the counter; if illegal, do nothing.
    - When a legal move brings the counter to 0: clear move_cnt to 0000 and go to IDLE on the same edge.
  - IDLE:
    - If board equals the goal, go to SOLVED next edge; any rise in that cycle is ignored.
    - Else a center rise -> SHUF (reshuffle; move_cnt is cleared at the end of the shuffle).
    - Else the highest-priority direction rise is processed. Legal: apply the move and increment move_cnt in BCD. Illegal: no change to board or counter.
- Solved timing: solved rises one cycle after the move that completes the goal board.
  - A shuffle that ends on the goal board also enters SOLVED one cycle after entering IDLE.
- Counter rules:
  - BCD increment with digit carry (0009 -> 0010, 0999 -> 1000).
  - Saturates at 9999; further legal moves still update the board.
- Reset asserted mid-shuffle or mid-game returns everything to the reset values immediately.

Test Plan:
- Reset: hold rst_n=0, release -> board=36'h087654321, blank_pos=8, move_cnt=0000, solved=1, busy=0. Pulse up/left -> no change.
- SHUFFLE_MOVES=1: center pulse -> busy=1 until one legal move (blank_pos 5 or 7); busy=0, move_cnt=0000, solved=0. Opposite direction (down or right) -> goal board, move_cnt=0001, solved=1 exactly one cycle later.
- From IDLE with blank_pos=8: down and right pulses -> board and counter unchanged. Up -> blank_pos=5, old pos-5 tile now at pos 8, move_cnt +1.
- Simultaneous rise of up+left in IDLE -> only up applied. Holding up for 10 cycles -> exactly one move.
- 10000 alternating up/down pulses in IDLE -> move_cnt counts 0009->0010, 0999->1000, and stops at 9999. Board keeps toggling.
- Default SHUFFLE_MOVES=64: assert rst_n=0 while busy=1 -> all outputs at reset values asynchronously. After release, center -> busy for >= 64 cycles, board remains a permutation of 0..8.

Source files
------------

// File: rtl/puzzle_move_ctrl.sv
// 8-puzzle game controller: button-edge moves, LFSR shuffle, BCD move counter
// and solved detection for a 3x3 board register.
module puzzle_move_ctrl #(
    parameter int unsigned SHUFFLE_MOVES = 64,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  btn,
    output logic [35:0] board,
    output logic [3:0]  blank_pos,
    output logic [15:0] move_cnt,
    output logic        solved,
    output logic        busy
);

    localparam logic [35:0] GOAL      = 36'h0_8765_4321;
    localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [7:0]  SHUF_LOAD = 8'(SHUFFLE_MOVES);

    localparam logic [1:0] SOLVED = 2'd0;
    localparam logic [1:0] SHUF   = 2'd1;
    localparam logic [1:0] IDLE   = 2'd2;

    logic [1:0]  state;
    logic [4:0]  btn_q;
    logic [15:0] lfsr;
    logic [7:0]  shuf_cnt;

    logic [4:0]  rise;
    logic [1:0]  dir;
    logic        dir_valid;
    logic [1:0]  col;
    logic        legal;
    logic [3:0]  new_pos;
    logic        do_move;
    logic [3:0]  tile;
    logic [35:0] board_nxt;
    logic [15:0] bcd_nxt;
    logic        carry;

    assign rise    = btn & ~btn_q;
    assign do_move = dir_valid & legal;
    assign solved  = (state == SOLVED);
    assign busy    = (state == SHUF);

    // Direction source: LFSR while shuffling, highest-priority rise while playing.
    always_comb begin
        dir_valid = 1'b0;
        dir       = 2'd0;
        if (state == SHUF) begin
            dir_valid = 1'b1;
            dir       = lfsr[1:0];
        end else if (state == IDLE) begin
            if (rise[0]) begin
                dir_valid = 1'b1;
                dir       = 2'd0;
            end else if (rise[1]) begin
                dir_valid = 1'b1;
                dir       = 2'd1;
            end else if (rise[2]) begin
                dir_valid = 1'b1;
                dir       = 2'd2;
            end else if (rise[3]) begin
                dir_valid = 1'b1;
                dir       = 2'd3;
            end
        end
    end

    always_comb begin
        case (blank_pos)
            4'd0, 4'd3, 4'd6: col = 2'd0;
            4'd1, 4'd4, 4'd7: col = 2'd1;
            default:          col = 2'd2;
        endcase
    end

    always_comb begin
        legal   = 1'b0;
        new_pos = blank_pos;
        case (dir)
            2'd0: if (blank_pos >= 4'd3) begin legal = 1'b1; new_pos = blank_pos - 4'd3; end
            2'd1: if (blank_pos <= 4'd5) begin legal = 1'b1; new_pos = blank_pos + 4'd3; end
            2'd2: if (col != 2'd0)       begin legal = 1'b1; new_pos = blank_pos - 4'd1; end
            default: if (col != 2'd2)    begin legal = 1'b1; new_pos = blank_pos + 4'd1; end
        endcase
    end

    // Neighbour tile slides into the old blank slot; the new slot becomes blank.
    always_comb begin
        tile = 4'h0;
        for (int unsigned i = 0; i < 9; i++) begin
            if (4'(i) == new_pos) tile = board[4*i +: 4];
        end
        board_nxt = board;
        for (int unsigned i = 0; i < 9; i++) begin
            if (4'(i) == blank_pos)    board_nxt[4*i +: 4] = tile;
            else if (4'(i) == new_pos) board_nxt[4*i +: 4] = 4'h0;
        end
    end

    always_comb begin
        bcd_nxt = move_cnt;
        carry   = 1'b1;
        if (move_cnt != 16'h9999) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (carry) begin
                    if (move_cnt[4*i +: 4] == 4'd9) begin
                        bcd_nxt[4*i +: 4] = 4'd0;
                    end else begin
                        bcd_nxt[4*i +: 4] = move_cnt[4*i +: 4] + 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SOLVED;
            btn_q     <= '0;
            lfsr      <= SEED;
            shuf_cnt  <= '0;
            board     <= GOAL;
            blank_pos <= 4'd8;
            move_cnt  <= '0;
        end else begin
            btn_q <= btn;
            lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            case (state)
                SOLVED: begin
                    if (rise[4]) begin
                        state    <= SHUF;
                        shuf_cnt <= SHUF_LOAD;
                    end
                end
                SHUF: begin
                    if (do_move) begin
                        board     <= board_nxt;
                        blank_pos <= new_pos;
                        shuf_cnt  <= shuf_cnt - 8'd1;
                        if (shuf_cnt == 8'd1) begin
                            move_cnt <= '0;
                            state    <= IDLE;
                        end
                    end
                end
                IDLE: begin
                    if (board == GOAL) begin
                        state <= SOLVED;
                    end else if (rise[4]) begin
                        state    <= SHUF;
                        shuf_cnt <= SHUF_LOAD;
                    end else if (do_move) begin
                        board     <= board_nxt;
                        blank_pos <= new_pos;
                        move_cnt  <= bcd_nxt;
                    end
                end
                default: state <= SOLVED;
            endcase
        end
    end

endmodule
